// File: rtl/seq_trigger.sv
// seq_trigger
// Multi-stage sequential trigger for the logic analyzer. Every stage compares
// CH lanes of the sampled input against per-lane conditions. The lane results
// are combined with AND or OR, and the stage must collect a programmable number
// of hits before the sequence moves on. When the final stage is satisfied, a
// single trig pulse goes to the capture controller.
//
// Ports:
//   clk, rstn    clock, synchronous active-low reset
//   arm          pulse: latch configuration, start the sequence at stage 0
//   abort        pulse: return to IDLE (beats arm and stage advance)
//   in           sampled lanes, lane c = in[c*WIDTH +: WIDTH]
//   cfg_op       per stage/lane {operator[5:3], value code[2:0]}, index s*CH+c
//   cfg_val      per stage/lane compare value, index s*CH+c
//   cfg_and      per stage: 1 = all lanes must hit, 0 = any lane hits
//   cfg_cnt      per stage hit count required (0 counts as 1)
//   cfg_last     index of the final stage, clamped to STAGES-1
//   cfg_timeout  (SEQ_TRIG_TIMEOUT_EN only) stage timeout in cycles, 0 = off
//   armed        high while the sequence is running
//   trig         one-cycle pulse on sequence completion
//   triggered    sticky completion flag, cleared by arm or abort
//   stage        current stage index
//
// Optional feature macro: SEQ_TRIG_TIMEOUT_EN adds the cfg_timeout port and a
// timer that drops the sequence back to stage 0 when a later stage waits too long.

module seq_trigger #(
    parameter int WIDTH  = 8,
    parameter int CH     = 4,
    parameter int STAGES = 4,
    parameter int CNT_W  = 16,
    localparam int SW    = $clog2(STAGES) + 1
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        arm,
    input  logic                        abort,
    input  logic [CH*WIDTH-1:0]         in,
    input  logic [STAGES*CH*6-1:0]      cfg_op,
    input  logic [STAGES*CH*WIDTH-1:0]  cfg_val,
    input  logic [STAGES-1:0]           cfg_and,
    input  logic [STAGES*CNT_W-1:0]     cfg_cnt,
    input  logic [SW-1:0]               cfg_last,
`ifdef SEQ_TRIG_TIMEOUT_EN
    input  logic [15:0]                 cfg_timeout,
`endif
    output logic                        armed,
    output logic                        trig,
    output logic                        triggered,
    output logic [SW-1:0]               stage
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [SW-1:0] LAST_MAX = SW'(STAGES - 1);

    state_t                        state_q, state_d;
    logic [SW-1:0]                 stage_q, stage_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic                          trig_q, trig_d;
    logic                          triggered_q, triggered_d;
    logic                          armed_q, armed_d;
    logic [CH*WIDTH-1:0]           in_dly_q, in_dly_d;
    logic [STAGES*CH-1:0]          hit_q, hit_d;
    logic [STAGES*CH*6-1:0]        op_sh_q, op_sh_d;
    logic [STAGES*CH*WIDTH-1:0]    val_sh_q, val_sh_d;
    logic [STAGES-1:0]             and_sh_q, and_sh_d;
    logic [STAGES*CNT_W-1:0]       cnt_sh_q, cnt_sh_d;
    logic [SW-1:0]                 last_sh_q, last_sh_d;
`ifdef SEQ_TRIG_TIMEOUT_EN
    logic [15:0]                   timer_q, timer_d;
    logic [15:0]                   to_sh_q, to_sh_d;
`endif

    logic [STAGES*CH*6-1:0]        op_src;
    logic [STAGES*CH*WIDTH-1:0]    val_src;
    logic [CH-1:0]                 cur_hits;
    logic                          cur_and;
    logic [CNT_W-1:0]              cur_need;
    logic [CNT_W-1:0]              need_eff;
    logic [CNT_W:0]                cnt_inc;
    logic                          stage_hit;
    logic                          advance;

    // One lane condition: codes 0-6 only valid with operator 0, code 7 is a
    // numeric compare against the lane's configured value. All unsigned.
    function automatic logic lane_hit(input logic [5:0]       opc,
                                      input logic [WIDTH-1:0] cur,
                                      input logic [WIDTH-1:0] dly,
                                      input logic [WIDTH-1:0] cmp_val);
        logic [2:0] oper;
        logic [2:0] code;
        logic       res;
        oper = opc[5:3];
        code = opc[2:0];
        res  = 1'b0;
        if (code != 3'd7) begin
            if (oper == 3'd0) begin
                case (code)
                    3'd0:    res = (cur == '0);
                    3'd1:    res = (cur == '1);
                    3'd2:    res = 1'b1;
                    3'd3:    res = (cur > dly);
                    3'd4:    res = (cur < dly);
                    3'd5:    res = (cur != dly);
                    3'd6:    res = (cur == dly);
                    default: res = 1'b0;
                endcase
            end
        end else begin
            case (oper)
                3'd0:    res = (cur == cmp_val);
                3'd1:    res = (cur != cmp_val);
                3'd2:    res = (cur <  cmp_val);
                3'd3:    res = (cur <= cmp_val);
                3'd4:    res = (cur >  cmp_val);
                3'd5:    res = (cur >= cmp_val);
                default: res = 1'b0;
            endcase
        end
        return res;
    endfunction

    // Outside RUN the hits are computed from the live configuration, so the
    // sample taken in the arm cycle is judged by the config being latched.
    assign op_src  = (state_q == RUN) ? op_sh_q  : cfg_op;
    assign val_src = (state_q == RUN) ? val_sh_q : cfg_val;

    // Hits for every stage and lane are registered, so the stage that is
    // current when the register is read always sees its own condition.
    always_comb begin
        in_dly_d = in;
        hit_d    = '0;
        for (int s = 0; s < STAGES; s++) begin
            for (int c = 0; c < CH; c++) begin
                hit_d[s*CH+c] = lane_hit(op_src[(s*CH+c)*6 +: 6],
                                         in[c*WIDTH +: WIDTH],
                                         in_dly_q[c*WIDTH +: WIDTH],
                                         val_src[(s*CH+c)*WIDTH +: WIDTH]);
            end
        end
    end

    // Select the current stage's registered hits and shadow settings.
    always_comb begin
        cur_hits = '0;
        cur_and  = 1'b0;
        cur_need = '0;
        for (int s = 0; s < STAGES; s++) begin
            if (SW'(s) == stage_q) begin
                cur_hits = hit_q[s*CH +: CH];
                cur_and  = and_sh_q[s];
                cur_need = cnt_sh_q[s*CNT_W +: CNT_W];
            end
        end
    end

    assign stage_hit = cur_and ? (&cur_hits) : (|cur_hits);
    assign need_eff  = (cur_need == '0) ? CNT_W'(1) : cur_need;
    assign cnt_inc   = {1'b0, cnt_q} + (CNT_W+1)'(1);

    // Sequencer next state: abort first, then arm from IDLE/DONE, then the
    // current stage's hit counting and advance while running.
    always_comb begin
        state_d     = state_q;
        stage_d     = stage_q;
        cnt_d       = cnt_q;
        trig_d      = 1'b0;
        triggered_d = triggered_q;
        op_sh_d     = op_sh_q;
        val_sh_d    = val_sh_q;
        and_sh_d    = and_sh_q;
        cnt_sh_d    = cnt_sh_q;
        last_sh_d   = last_sh_q;
        advance     = 1'b0;
`ifdef SEQ_TRIG_TIMEOUT_EN
        timer_d     = timer_q;
        to_sh_d     = to_sh_q;
`endif
        if (abort) begin
            state_d     = IDLE;
            stage_d     = '0;
            cnt_d       = '0;
            triggered_d = 1'b0;
`ifdef SEQ_TRIG_TIMEOUT_EN
            timer_d     = '0;
`endif
        end else begin
            case (state_q)
                RUN: begin
                    if (stage_hit) begin
                        if (cnt_inc >= {1'b0, need_eff}) begin
                            advance = 1'b1;
                            cnt_d   = '0;
                            if (stage_q == last_sh_q) begin
                                state_d     = DONE;
                                trig_d      = 1'b1;
                                triggered_d = 1'b1;
                            end else begin
                                stage_d = stage_q + 1'b1;
                            end
                        end else begin
                            cnt_d = cnt_inc[CNT_W-1:0];
                        end
                    end
`ifdef SEQ_TRIG_TIMEOUT_EN
                    if (advance || stage_q == '0) begin
                        timer_d = '0;
                    end else if (to_sh_q != '0) begin
                        if (timer_q + 16'd1 >= to_sh_q) begin
                            stage_d = '0;
                            cnt_d   = '0;
                            timer_d = '0;
                        end else begin
                            timer_d = timer_q + 16'd1;
                        end
                    end
`endif
                end
                default: begin
                    if (arm) begin
                        state_d     = RUN;
                        stage_d     = '0;
                        cnt_d       = '0;
                        triggered_d = 1'b0;
                        op_sh_d     = cfg_op;
                        val_sh_d    = cfg_val;
                        and_sh_d    = cfg_and;
                        cnt_sh_d    = cfg_cnt;
                        last_sh_d   = (cfg_last > LAST_MAX) ? LAST_MAX : cfg_last;
`ifdef SEQ_TRIG_TIMEOUT_EN
                        timer_d     = '0;
                        to_sh_d     = cfg_timeout;
`endif
                    end
                end
            endcase
        end
        armed_d = (state_d == RUN);
    end

    // All state, including the shadow configuration, returns to zero on reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            stage_q     <= '0;
            cnt_q       <= '0;
            trig_q      <= 1'b0;
            triggered_q <= 1'b0;
            armed_q     <= 1'b0;
            in_dly_q    <= '0;
            hit_q       <= '0;
            op_sh_q     <= '0;
            val_sh_q    <= '0;
            and_sh_q    <= '0;
            cnt_sh_q    <= '0;
            last_sh_q   <= '0;
`ifdef SEQ_TRIG_TIMEOUT_EN
            timer_q     <= '0;
            to_sh_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            stage_q     <= stage_d;
            cnt_q       <= cnt_d;
            trig_q      <= trig_d;
            triggered_q <= triggered_d;
            armed_q     <= armed_d;
            in_dly_q    <= in_dly_d;
            hit_q       <= hit_d;
            op_sh_q     <= op_sh_d;
            val_sh_q    <= val_sh_d;
            and_sh_q    <= and_sh_d;
            cnt_sh_q    <= cnt_sh_d;
            last_sh_q   <= last_sh_d;
`ifdef SEQ_TRIG_TIMEOUT_EN
            timer_q     <= timer_d;
            to_sh_q     <= to_sh_d;
`endif
        end
    end

    assign armed     = armed_q;
    assign trig      = trig_q;
    assign triggered = triggered_q;
    assign stage     = stage_q;

endmodule

// File: tb/tb_seq_trigger.sv
// tb_seq_trigger
// Bench for seq_trigger with default parameters. A sample-history model of the
// trigger sequence predicts armed/trig/triggered/stage for every cycle, and a
// few directed scenarios pin the expected outputs with literal values.

module tb_seq_trigger;

    localparam int WIDTH  = 8;
    localparam int CH     = 4;
    localparam int STAGES = 4;
    localparam int CNT_W  = 16;
    localparam int SW     = $clog2(STAGES) + 1;

    logic                        clk = 1'b0;
    logic                        rstn = 1'b0;
    logic                        arm = 1'b0;
    logic                        abort = 1'b0;
    logic [CH*WIDTH-1:0]         in_v = '0;
    logic [STAGES*CH*6-1:0]      cfg_op = '0;
    logic [STAGES*CH*WIDTH-1:0]  cfg_val = '0;
    logic [STAGES-1:0]           cfg_and = '0;
    logic [STAGES*CNT_W-1:0]     cfg_cnt = '0;
    logic [SW-1:0]               cfg_last = '0;
`ifdef SEQ_TRIG_TIMEOUT_EN
    logic [15:0]                 cfg_timeout = '0;
`endif
    logic                        armed;
    logic                        trig;
    logic                        triggered;
    logic [SW-1:0]               stage;

    int n_cmp  = 0;
    int n_fail = 0;

    seq_trigger #(.WIDTH(WIDTH), .CH(CH), .STAGES(STAGES), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .arm       (arm),
        .abort     (abort),
        .in        (in_v),
        .cfg_op    (cfg_op),
        .cfg_val   (cfg_val),
        .cfg_and   (cfg_and),
        .cfg_cnt   (cfg_cnt),
        .cfg_last  (cfg_last),
`ifdef SEQ_TRIG_TIMEOUT_EN
        .cfg_timeout(cfg_timeout),
`endif
        .armed     (armed),
        .trig      (trig),
        .triggered (triggered),
        .stage     (stage)
    );

    always #5 clk = ~clk;

    // One comparison: counts it, and reports a mismatch including X/Z.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, wait for the edge, return 1 ns after it.
    task automatic applyStimulus(input logic [CH*WIDTH-1:0] v, input logic a, input logic ab);
        in_v  = v;
        arm   = a;
        abort = ab;
        @(posedge clk);
        #1;
        arm   = 1'b0;
        abort = 1'b0;
    endtask

    function automatic logic [CH*WIDTH-1:0] lanes(input logic [7:0] l3, input logic [7:0] l2,
                                                  input logic [7:0] l1, input logic [7:0] l0);
        return {l3, l2, l1, l0};
    endfunction

    // Meaning of one lane condition, straight from the operator/code table.
    function automatic bit lane_ok(input logic [5:0] opc, input logic [7:0] cur,
                                   input logic [7:0] dly, input logic [7:0] v);
        int o;
        int k;
        o = int'(opc[5:3]);
        k = int'(opc[2:0]);
        if (k == 7) begin
            case (o)
                0: return cur == v;
                1: return cur != v;
                2: return cur < v;
                3: return cur <= v;
                4: return cur > v;
                5: return cur >= v;
                default: return 1'b0;
            endcase
        end
        if (o != 0) return 1'b0;
        case (k)
            0: return cur == 8'h00;
            1: return cur == 8'hFF;
            2: return 1'b1;
            3: return cur > dly;
            4: return cur < dly;
            5: return cur != dly;
            6: return cur == dly;
            default: return 1'b0;
        endcase
    endfunction

    // Model state: running flag, stage, hit count, last two samples per lane.
    bit          m_ok = 1'b0;
    bit          m_run, m_trig, m_trd, hv;
    int          m_stage, m_cnt, m_nh, m_last;
    bit          m_sh;
    logic [7:0]  s1 [CH];
    logic [7:0]  s2 [CH];
    logic [5:0]  l_op  [STAGES][CH];
    logic [7:0]  l_val [STAGES][CH];
    bit          l_and [STAGES];
    int          l_need[STAGES];

    // Each edge judges the previous cycle's sample against the current stage,
    // then records the new sample.
    always @(posedge clk) begin
        if (!rstn) begin
            m_run = 0; m_trig = 0; m_trd = 0; m_stage = 0; m_cnt = 0; hv = 0;
            for (int c = 0; c < CH; c++) begin
                s1[c] = 8'h00;
                s2[c] = 8'h00;
            end
            m_ok = 1'b1;
        end else begin
            m_nh = 0;
            if (m_run && hv)
                for (int c = 0; c < CH; c++)
                    if (lane_ok(l_op[m_stage][c], s1[c], s2[c], l_val[m_stage][c])) m_nh++;
            m_sh = m_run && hv && (l_and[m_stage] ? (m_nh == CH) : (m_nh > 0));
            m_trig = 0;
            if (abort) begin
                m_run = 0; m_stage = 0; m_cnt = 0; m_trd = 0;
            end else if (arm && !m_run) begin
                for (int s = 0; s < STAGES; s++) begin
                    for (int c = 0; c < CH; c++) begin
                        l_op[s][c]  = cfg_op[(s*CH+c)*6 +: 6];
                        l_val[s][c] = cfg_val[(s*CH+c)*WIDTH +: WIDTH];
                    end
                    l_and[s]  = cfg_and[s];
                    l_need[s] = int'(cfg_cnt[s*CNT_W +: CNT_W]);
                    if (l_need[s] == 0) l_need[s] = 1;
                end
                m_last  = (int'(cfg_last) > STAGES-1) ? STAGES-1 : int'(cfg_last);
                m_run   = 1; m_stage = 0; m_cnt = 0; m_trd = 0;
            end else if (m_sh) begin
                m_cnt++;
                if (m_cnt >= l_need[m_stage]) begin
                    m_cnt = 0;
                    if (m_stage == m_last) begin
                        m_run = 0; m_trig = 1; m_trd = 1;
                    end else begin
                        m_stage++;
                    end
                end
            end
            for (int c = 0; c < CH; c++) begin
                s2[c] = s1[c];
                s1[c] = in_v[c*WIDTH +: WIDTH];
            end
            hv = 1'b1;
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        if (m_ok) begin
            checkOutput("model armed", 32'(armed), 32'(m_run));
            checkOutput("model trig", 32'(trig), 32'(m_trig));
            checkOutput("model triggered", 32'(triggered), 32'(m_trd));
            checkOutput("model stage", 32'(stage), 32'(m_stage));
        end
    end

    // All lanes false (operator 6), OR mode, one hit per stage, last stage 0.
    task automatic clearCfg();
        for (int i = 0; i < STAGES*CH; i++) begin
            cfg_op[i*6 +: 6]          = {3'd6, 3'd0};
            cfg_val[i*WIDTH +: WIDTH] = 8'h00;
        end
        cfg_and  = '0;
        for (int s = 0; s < STAGES; s++) cfg_cnt[s*CNT_W +: CNT_W] = 16'd1;
        cfg_last = '0;
    endtask

    task automatic setLane(input int s, input int c, input logic [2:0] oper,
                           input logic [2:0] code, input logic [7:0] v);
        cfg_op[(s*CH+c)*6 +: 6]          = {oper, code};
        cfg_val[(s*CH+c)*WIDTH +: WIDTH] = v;
    endtask

    function automatic logic [7:0] pickVal();
        case ($urandom_range(0, 3))
            0: return 8'h00;
            1: return 8'h01;
            2: return 8'h02;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [CH*WIDTH-1:0] randIn();
        logic [CH*WIDTH-1:0] v;
        for (int c = 0; c < CH; c++) v[c*WIDTH +: WIDTH] = pickVal();
        return v;
    endfunction

    task automatic randomCfg();
        logic [2:0] code;
        logic [2:0] oper;
        for (int i = 0; i < STAGES*CH; i++) begin
            code = 3'($urandom_range(0, 7));
            if (code == 3'd7) oper = 3'($urandom_range(0, 7));
            else if ($urandom_range(0, 4) == 0) oper = 3'($urandom_range(1, 7));
            else oper = 3'd0;
            cfg_op[i*6 +: 6]          = {oper, code};
            cfg_val[i*WIDTH +: WIDTH] = pickVal();
        end
        cfg_and = STAGES'($urandom_range(0, (1 << STAGES) - 1));
        for (int s = 0; s < STAGES; s++) cfg_cnt[s*CNT_W +: CNT_W] = 16'($urandom_range(0, 3));
        cfg_last = SW'($urandom_range(0, 7));
    endtask

    int pat2 [9] = '{1, 0, 0, 1, 1, 0, 1, 0, 0};

    initial begin
        logic a, ab;
        clearCfg();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset armed", 32'(armed), 0);
        checkOutput("reset trig", 32'(trig), 0);
        checkOutput("reset triggered", 32'(triggered), 0);
        checkOutput("reset stage", 32'(stage), 0);
        rstn = 1'b1;
        applyStimulus('0, 0, 0);

        // Single NUM == 0x55 compare, trig two cycles after the sample.
        clearCfg();
        setLane(0, 0, 3'd0, 3'd7, 8'h55);
        applyStimulus('0, 1, 0);
        checkOutput("t1 armed after arm", 32'(armed), 1);
        applyStimulus(lanes(0, 0, 0, 8'h55), 0, 0);
        checkOutput("t1 trig at t+1", 32'(trig), 0);
        applyStimulus('0, 0, 0);
        checkOutput("t1 trig at t+2", 32'(trig), 1);
        checkOutput("t1 triggered", 32'(triggered), 1);
        checkOutput("t1 armed done", 32'(armed), 0);
        applyStimulus('0, 0, 0);
        checkOutput("t1 trig one cycle", 32'(trig), 0);
        checkOutput("t1 triggered sticky", 32'(triggered), 1);

        // Three non-consecutive rises on lane1.
        clearCfg();
        setLane(0, 1, 3'd0, 3'd3, 8'h00);
        cfg_cnt[0 +: CNT_W] = 16'd3;
        applyStimulus('0, 1, 0);
        checkOutput("t2 triggered cleared by arm", 32'(triggered), 0);
        for (int i = 0; i < 9; i++) begin
            applyStimulus(lanes(0, 0, 8'(pat2[i]), 0), 0, 0);
            checkOutput("t2 rise count trig", 32'(trig), (i == 7) ? 1 : 0);
        end

        // Two stages: s0 lane0==10 AND lane1>20, s1 lane2 CHANGE.
        clearCfg();
        setLane(0, 0, 3'd0, 3'd7, 8'd10);
        setLane(0, 1, 3'd4, 3'd7, 8'd20);
        setLane(0, 2, 3'd0, 3'd2, 8'd0);
        setLane(0, 3, 3'd0, 3'd2, 8'd0);
        cfg_and[0] = 1'b1;
        setLane(1, 2, 3'd0, 3'd5, 8'd0);
        cfg_last = 3'd1;
        applyStimulus('0, 1, 0);
        applyStimulus(lanes(0, 5, 0, 0), 0, 0);
        applyStimulus(lanes(0, 9, 0, 0), 0, 0);
        applyStimulus(lanes(0, 1, 0, 0), 0, 0);
        checkOutput("t3 s1 first no advance", 32'(stage), 0);
        applyStimulus(lanes(0, 1, 30, 10), 0, 0);
        checkOutput("t3 stage t+1", 32'(stage), 0);
        applyStimulus(lanes(0, 1, 0, 0), 0, 0);
        checkOutput("t3 stage advanced", 32'(stage), 1);
        applyStimulus(lanes(0, 1, 0, 0), 0, 0);
        applyStimulus(lanes(0, 7, 0, 0), 0, 0);
        checkOutput("t3 no early trig", 32'(trig), 0);
        applyStimulus(lanes(0, 7, 0, 0), 0, 0);
        checkOutput("t3 trig", 32'(trig), 1);
        applyStimulus(lanes(0, 7, 0, 0), 0, 0);
        checkOutput("t3 stage hold", 32'(stage), 1);

        // Abort together with arm while in stage 1.
        applyStimulus('0, 1, 0);
        applyStimulus(lanes(0, 0, 30, 10), 0, 0);
        applyStimulus('0, 0, 0);
        checkOutput("t4 in stage 1", 32'(stage), 1);
        applyStimulus(lanes(0, 3, 0, 0), 1, 1);
        checkOutput("t4 abort armed", 32'(armed), 0);
        checkOutput("t4 abort stage", 32'(stage), 0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(lanes(0, 8'(i * 3), 0, 0), 0, 0);
            checkOutput("t4 no trig after abort", 32'(trig), 0);
        end

        // cfg_last clamp, cnt 0 as 1, live config ignored while running.
        clearCfg();
        for (int s = 0; s < STAGES; s++) begin
            setLane(s, 0, 3'd0, 3'd7, 8'(s + 1));
            cfg_cnt[s*CNT_W +: CNT_W] = 16'd0;
        end
        cfg_last = 3'd7;
        applyStimulus('0, 1, 0);
        cfg_last = 3'd0;
        for (int s = 0; s < STAGES; s++) cfg_cnt[s*CNT_W +: CNT_W] = 16'd5;
        setLane(0, 0, 3'd0, 3'd7, 8'd99);
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(lanes(0, 0, 0, 8'(i)), 0, 0);
            checkOutput("t5 stage walk", 32'(stage), 32'(i - 1));
        end
        applyStimulus('0, 0, 0);
        checkOutput("t5 trig after clamp", 32'(trig), 1);
        checkOutput("t5 final stage", 32'(stage), 3);

        // Randomized traffic, with live config churn, arms, aborts and resets.
        for (int r = 0; r < 25; r++) begin
            randomCfg();
            applyStimulus(randIn(), 1, 0);
            for (int k = 0; k < 160; k++) begin
                if (k % 40 == 20) randomCfg();
                a  = ($urandom_range(0, 24) == 0);
                ab = ($urandom_range(0, 79) == 0);
                if ($urandom_range(0, 199) == 0) rstn = 1'b0;
                applyStimulus(randIn(), a, ab);
                rstn = 1'b1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
